// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one bit per clock with a registered borrow.
// Ports: clk, rst (async, active-high), start (accepted only in IDLE), A/B (operands sampled on accept),
//        busy (RUN or DONE_S), done (one-cycle result-valid pulse), DIFF (A - B mod 2^WIDTH),
//        BORROW (1 when A < B unsigned), OVF (signed overflow, only with SERIAL_SUBTRACTOR_OVF_EN).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             OVF
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic [CW-1:0] cnt;
    logic brw, brw_nxt, d, last;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb, b_msb;
`endif
    always_comb begin
        d         = a_sr[0] ^ b_sr[0] ^ brw;
        brw_nxt   = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & brw) | (b_sr[0] & brw);
        last      = cnt == CW'(WIDTH - 1);
        state_nxt = (state == IDLE) ? (start ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE_S : RUN) : IDLE;
        busy      = state != IDLE;
        done      = state == DONE_S;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            DIFF   <= '0;
            BORROW <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            OVF    <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a_sr   <= A;
            b_sr   <= B;
            brw    <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
`endif
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            r_sr   <= {d, r_sr[WIDTH-1:1]};
            brw    <= brw_nxt;
            cnt    <= cnt + 1'b1;
            // the MSB bit is merged straight into DIFF rather than waiting for r_sr
            if (last) begin
                DIFF   <= {d, r_sr[WIDTH-1:1]};
                BORROW <= brw_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                OVF    <= (a_msb != b_msb) && (d != a_msb);
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst, start, busy, done, borrow;
    logic [7:0] a, b, diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       ovf;
`endif
    int total = 0;
    int bad = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
        .busy(busy), .done(done), .DIFF(diff), .BORROW(borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .OVF(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one operation, watch a WIDTH+2 window, optionally poke start during RUN and DONE_S.
    task automatic op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb, input logic eo, input logic inj);
        int bc = 0;
        int dc = 0;
        int first = -1;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            if (busy) bc++;
            if (done) begin
                dc++;
                if (first < 0) first = i;
            end
            if (inj && (i == 3 || i == 8)) begin
                start = 1'b1;
                a = 8'h01;
                b = 8'h01;
            end else begin
                start = 1'b0;
            end
            if (i != 9) tick();
        end
        start = 1'b0;
        chk({tag, "_latency"}, first, 8);
        chk({tag, "_busy_cycles"}, bc, 9);
        chk({tag, "_done_pulses"}, dc, 1);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow, eb);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk({tag, "_ovf"}, ovf, eo);
`else
        if (eo) chk({tag, "_ovf_unused"}, 0, 0 + int'(eo) - 1);
`endif
    endtask

    initial begin
        int dc;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_diff", diff, 0);
        chk("reset_borrow", borrow, 0);
        rst = 1'b0;
        tick();
        op("basic",   8'h0A, 8'h03, 8'h07, 1'b0, 1'b0, 1'b0);
        op("neg",     8'h03, 8'h0A, 8'hF9, 1'b1, 1'b0, 1'b0);
        op("zero_m1", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        op("ff_ff",   8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        op("zz",      8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        op("hs",      8'h20, 8'h10, 8'h10, 1'b0, 1'b0, 1'b1);
        op("hs_next", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0);
        a = 8'h40;
        b = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_borrow", borrow, 0);
        tick();
        rst = 1'b0;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) dc++;
            tick();
        end
        chk("midrst_no_done", dc, 0);
        op("after_rst", 8'h05, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
        op("ovf_pos",   8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        op("ovf_neg",   8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
        op("ovf_none",  8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
